ifu_prefetch: RTL



---
 rtl/ifu_prefetch_pkg.sv | 22 ++
 rtl/ifu_prefetch_if.sv | 47 ++++
 rtl/ifu_prefetch_fetch_fifo.sv | 58 +++++
 rtl/ifu_prefetch.sv | 100 ++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared widths, reset PC and small helpers for the instruction prefetch unit.
package ifu_prefetch_pkg;

    localparam int unsigned InstBus     = 32;
    localparam int unsigned InstAddrBus = 32;
    localparam logic [InstAddrBus-1:0] PcResetVal = 32'h8000_0000;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_KEEP,
        RSP_DROP
    } rsp_action_e;

    function automatic int unsigned pc_step(input int unsigned inst_w);
        return inst_w / 8;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-side bus: memory request/response, decode handoff and execute redirect.
interface ifu_prefetch_if import ifu_prefetch_pkg::*; #(
    parameter int unsigned ADDR_W = InstAddrBus,
    parameter int unsigned INST_W = InstBus
) ();

    logic              req_valid_o;
    logic              req_ready_i;
    logic [ADDR_W-1:0] req_addr_o;
    logic              rsp_valid_i;
    logic [INST_W-1:0] rsp_inst_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;

    modport master (
        output req_valid_o,
        input  req_ready_i,
        output req_addr_o,
        input  rsp_valid_i,
        input  rsp_inst_i,
        output inst_valid_o,
        input  inst_ready_i,
        output inst_o,
        output pc_o,
        input  redirect_i,
        input  redirect_pc_i
    );

    modport slave (
        input  req_valid_o,
        output req_ready_i,
        input  req_addr_o,
        output rsp_valid_i,
        output rsp_inst_i,
        input  inst_valid_o,
        output inst_ready_i,
        input  inst_o,
        input  pc_o,
        output redirect_i,
        output redirect_pc_i
    );

endinterface

// File: rtl/ifu_prefetch_fetch_fifo.sv
// Synchronous prefetch queue; flush wins over push/pop, pointers carry an extra wrap bit.
module fetch_fifo import ifu_prefetch_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned CNT_W = ptr_width(DEPTH);
    localparam int unsigned IDX_W = CNT_W - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        count_o  = wr_ptr_q - rd_ptr_q;
        full_o   = (count_o == CNT_W'(DEPTH));
        empty_o  = (wr_ptr_q == rd_ptr_q);
        data_o   = mem_q[rd_ptr_q[IDX_W-1:0]];
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: credit-limited fetch requests, PC-tagged
// response queue toward decode, and redirect flush with in-flight response dropping.
module ifu_prefetch import ifu_prefetch_pkg::*; #(
    parameter int unsigned       ADDR_W   = InstAddrBus,
    parameter int unsigned       INST_W   = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PcResetVal),
    parameter int unsigned       DEPTH    = 4
) (
    input logic            clk,
    input logic            rst,
    ifu_prefetch_if.master bus
);

    localparam int unsigned       CNT_W  = ptr_width(DEPTH);
    localparam int unsigned       SUM_W  = CNT_W + 1;
    localparam logic [ADDR_W-1:0] PcInc  = ADDR_W'(pc_step(INST_W));
    localparam logic [SUM_W-1:0]  Credit = SUM_W'(DEPTH);

    logic [ADDR_W-1:0]        fpc_q, fpc_d;
    logic [ADDR_W-1:0]        rpc_q, rpc_d;
    logic [CNT_W-1:0]         outst_q, outst_d;
    logic [CNT_W-1:0]         drop_q, drop_d;
    logic [CNT_W-1:0]         occ;
    logic                     fifo_full, fifo_empty;
    logic [ADDR_W+INST_W-1:0] head;
    logic [ADDR_W-1:0]        redir_pc;
    logic                     req_fire, rsp_fire, push, pop;
    rsp_action_e              rsp_act;
    logic                     unused_redir_lsb;

    assign unused_redir_lsb = ^bus.redirect_pc_i[1:0];

    always_comb begin
        redir_pc         = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
        bus.req_valid_o  = ~rst & ~bus.redirect_i & (({1'b0, occ} + {1'b0, outst_q}) < Credit);
        bus.req_addr_o   = rst ? RESET_PC : fpc_q;
        bus.inst_valid_o = ~rst & ~fifo_empty & ~bus.redirect_i;
        bus.inst_o       = (rst | fifo_empty) ? '0 : head[INST_W-1:0];
        bus.pc_o         = (rst | fifo_empty) ? '0 : head[ADDR_W+INST_W-1:INST_W];

        req_fire = bus.req_valid_o & bus.req_ready_i;
        // Unsolicited responses (nothing outstanding) are ignored entirely.
        rsp_fire = bus.rsp_valid_i & (outst_q != '0);
        rsp_act  = RSP_NONE;
        if (rsp_fire) rsp_act = (bus.redirect_i || drop_q != '0) ? RSP_DROP : RSP_KEEP;
        push = (rsp_act == RSP_KEEP);
        pop  = bus.inst_valid_o & bus.inst_ready_i;

        fpc_d   = fpc_q;
        rpc_d   = rpc_q;
        drop_d  = drop_q;
        outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        if (bus.redirect_i) begin
            fpc_d  = redir_pc;
            rpc_d  = redir_pc;
            // Everything still in flight after this edge belongs to the abandoned path,
            // so the drop count saturates at the remaining outstanding count.
            drop_d = outst_q - CNT_W'(rsp_fire);
        end else begin
            if (req_fire)             fpc_d  = fpc_q + PcInc;
            if (rsp_act == RSP_KEEP)  rpc_d  = rpc_q + PcInc;
            if (rsp_act == RSP_DROP)  drop_d = drop_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q   <= RESET_PC;
            rpc_q   <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            fpc_q   <= fpc_d;
            rpc_q   <= rpc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_i),
        .data_i  ({rpc_q, bus.rsp_inst_i}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occ)
    );

    assert property (@(posedge clk) disable iff (rst) !(bus.rsp_valid_i && outst_q == '0));
    assert property (@(posedge clk) disable iff (rst) (({1'b0, occ} + {1'b0, outst_q}) <= Credit));
    assert property (@(posedge clk) disable iff (rst) !(fifo_full && push && !pop));

endmodule
